apb_up_master: RTL and testbench
================================

# apb_up_master

Single-outstanding APB initiator: the requester end of the 12-bit-address APB interface served by the user-plugin peripheral. It accepts one request at a time on a valid/ready channel, runs the APB SETUP/ACCESS sequence, waits for PREADY, and returns read data and error status on a valid/ready response channel. It sits between a local controller (test sequencer or plugin DMA) and any APB slave in the plugin subsystem.

## Interface
- APB_ADDR_WIDTH, default 12, width of request address and PADDR
- TIMEOUT_CYCLES, default 255, ACCESS-phase wait limit; used only with the timeout feature
- clk_i  in  1  clock; one clock domain
- rst_n  in  1  reset, synchronous and active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_addr_i  in  APB_ADDR_WIDTH  byte address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o
- rsp_rdata_o  out  32  read data; 0 for writes
- rsp_err_o  out  1  PSLVERR sampled at completion, or timeout
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready_o=1. On req_valid_i: capture addr/write/wdata into PADDR/PWRITE/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0. Always to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. If PREADY=1: capture rsp_rdata_o = PWRITE ? 0 : PRDATA and rsp_err_o = PSLVERR, go RESP. Otherwise stay.
- RESP: PSEL=0, PENABLE=0, rsp_valid_o=1. rsp_rdata_o/rsp_err_o stable until rsp_ready_i=1, then IDLE.
- req_ready_o=0 in every state except IDLE. No request is ever dropped or duplicated.
- PADDR/PWDATA/PWRITE change only on request acceptance. They hold the last transfer's values in IDLE/RESP.
- PRDATA/PSLVERR are ignored in every cycle except ACCESS with PREADY=1.

## Timing
- Reset (rst_n=0 at a clk_i edge): state IDLE. All outputs 0 except req_ready_o, which is 1 once the FSM is in IDLE. The same holds when reset arrives mid-transfer: PSEL/PENABLE are low after that edge and any pending response is discarded.
- Accept at edge N. PSEL=1 from N+1. PENABLE=1 from N+2.
- PREADY=1 at edge N+2+k (k wait states) gives rsp_valid_o=1 from N+3+k.
- Minimum period: 4 cycles per transfer when rsp_ready_i is held high.
- rsp_ready_i high on the first RESP cycle returns to IDLE the next cycle. No combinational path from any input to req_ready_o.

## Configuration
- Macro APB_UP_MASTER_TIMEOUT_EN.
- Defined: an 8-bit-min (clog2(TIMEOUT_CYCLES+1)) counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter equals TIMEOUT_CYCLES and PREADY is still 0, the transfer aborts: go RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - PSEL/PENABLE drop on the following cycle.
  - PREADY=1 on the limit cycle completes normally; completion has priority over timeout.
- Undefined: no counter logic; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Package apb_up_pkg: FSM state enum (apb_mst_state_e), response struct (rdata, err), default TIMEOUT_CYCLES constant.
- One natural sub-module: apb_up_wdog, the timeout counter. It is instantiated only under APB_UP_MASTER_TIMEOUT_EN and takes clear/inc inputs and a hit output.

## Test plan
- Write 0x5A5A_1234 to 0x010 with PREADY tied 1:
  - PSEL rises at N+1 and PENABLE at N+2, with PADDR=0x010, PWRITE=1, PWDATA=0x5A5A_1234.
  - rsp_valid_o at N+3 with rsp_rdata_o=0 and rsp_err_o=0.
- Read 0x004 with 3 wait states, slave returns 0xCAFE_F00D: rsp_valid_o at N+6 with rsp_rdata_o=0xCAFE_F00D. PENABLE stays high for 4 cycles.
- Read with PSLVERR=1 at completion, rsp_ready_i low for 5 cycles:
  - rsp_err_o=1; rsp_valid_o and rsp_rdata_o stay stable for all 5 cycles.
  - req_ready_o stays 0 until IDLE.
- Back-to-back: 8 requests with req_valid_i held high and rsp_ready_i=1 produce 8 responses in order, one every 4 cycles, with no extra PSEL pulses.
- rst_n asserted during ACCESS: PSEL=PENABLE=0 after the edge and rsp_valid_o never asserts. A subsequent request completes normally.
- With APB_UP_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY held 0: abort after 4 wait cycles with rsp_err_o=1 and rsp_rdata_o=0. Repeating with PREADY=1 on exactly the 4th wait cycle completes normally with rsp_err_o=0.

Source files
------------

// File: rtl/apb_up_pkg.sv
// Shared types for the APB up-master: FSM states, response record, watchdog sizing.
// Purely declarative; no logic lives here.
package apb_up_pkg;

    localparam int unsigned APB_UP_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } apb_rsp_t;

    // Counter is never narrower than 8 bits so small limits still fit comfortably.
    function automatic int unsigned wdog_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/apb_up_wdog.sv
// ACCESS-phase watchdog: counts wait cycles, flags when the count reaches LIMIT.
// Latency: hit is a registered-count compare; clear has priority over inc.
module apb_up_wdog
    import apb_up_pkg::*;
#(
    parameter int unsigned LIMIT = APB_UP_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic hit
);

    localparam int unsigned CNT_W = wdog_width(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/apb_up_master.sv
// Single-outstanding APB initiator; 4 cycles per transfer plus PREADY wait states, one request in flight.
// req_ready_o only in IDLE; response held until rsp_ready_i. Timeout abort via APB_UP_MASTER_TIMEOUT_EN.
module apb_up_master
    import apb_up_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = APB_UP_TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_write_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_mst_state_e state_q, state_d;
    apb_rsp_t       rsp_q;
    logic           accept;
    logic           complete;
    logic           abort;
    logic           timeout_hit;

`ifdef APB_UP_MASTER_TIMEOUT_EN
    apb_up_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .clear (state_q == SETUP),
        .inc   ((state_q == ACCESS) && !PREADY),
        .hit   (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // Completion wins over a timeout landing in the same cycle.
                if (PREADY) begin
                    complete = 1'b1;
                    state_d  = RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= IDLE;
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                PADDR  <= req_addr_i;
                PWDATA <= req_wdata_i;
                PWRITE <= req_write_i;
            end
            if (complete) begin
                rsp_q.rdata <= PWRITE ? 32'h0 : PRDATA;
                rsp_q.err   <= PSLVERR;
            end else if (abort) begin
                rsp_q.rdata <= 32'h0;
                rsp_q.err   <= 1'b1;
            end
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_apb_up_master.sv
// Directed bench for apb_up_master with a behavioural APB slave and a response scoreboard.
// Timeout scenarios are compiled in only when APB_UP_MASTER_TIMEOUT_EN is defined.
module tb_apb_up_master;
    import apb_up_pkg::*;

`ifdef APB_UP_MASTER_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk_i;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [11:0] req_addr_i;
    logic        req_write_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_up_master #(
        .APB_ADDR_WIDTH (12),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          last_acc;
    apb_rsp_t    sb[$];
    int          rsp_times[$];

    // Slave configuration, written only by the main sequence.
    bit          tie_ready = 0;
    int          wait_states = 0;
    logic [31:0] slave_rdata = 32'h0;
    bit          rd_mix = 0;
    logic        slave_err = 1'b0;
    bit          expect_timeout = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] slave_data(input logic [11:0] a);
        return slave_rdata ^ (rd_mix ? {20'h0, a} : 32'h0);
    endfunction

    // Behavioural slave: PREADY after wait_states ACCESS cycles, or tied high.
    initial begin : slave
        int wcnt;
        wcnt    = 0;
        PREADY  = 1'b0;
        PRDATA  = 32'h0;
        PSLVERR = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            if (tie_ready) begin
                PREADY = 1'b1;
            end else if (PSEL && PENABLE) begin
                PREADY = (wcnt == wait_states);
                wcnt++;
            end else begin
                PREADY = 1'b0;
                wcnt   = 0;
            end
            PRDATA  = slave_data(PADDR);
            PSLVERR = slave_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        apb_rsp_t e;
        bit acc;
        bit hs;
        acc = (req_valid_i === 1'b1) && (req_ready_o === 1'b1);
        hs  = (rsp_valid_o === 1'b1) && (rsp_ready_i === 1'b1);
        if (hs) begin
            rsp_times.push_back(cyc);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected observed=%0d expected=1+", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            end
        end
        if (acc) begin
            e.err   = expect_timeout ? 1'b1 : slave_err;
            e.rdata = (req_write_i || expect_timeout) ? 32'h0 : slave_data(req_addr_i);
            sb.push_back(e);
        end
        last_acc = acc;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_req(input logic [11:0] a, input logic w, input logic [31:0] d);
        int n;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_write_i = w;
        req_wdata_i = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        req_valid_i = 1'b0;
        chk("req_accept", 32'(last_acc), 32'd1);
    endtask

    task automatic wait_rsp(output int n, output int en);
        n  = 0;
        en = 0;
        while (rsp_valid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
            if (PENABLE === 1'b1) en++;
        end
    endtask

    initial begin : main
        int n;
        int en;
        int i;
        int rises;
        logic psel_prev;

        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write with PREADY tied high: SETUP, ACCESS, RESP on consecutive cycles.
        tie_ready = 1;
        do_req(12'h010, 1'b1, 32'h5A5A_1234);
        chk("wr_setup_psel", 32'(PSEL), 32'd1);
        chk("wr_setup_penable", 32'(PENABLE), 32'd0);
        chk("wr_setup_req_ready", 32'(req_ready_o), 32'd0);
        chk("wr_paddr", 32'(PADDR), 32'h010);
        chk("wr_pwrite", 32'(PWRITE), 32'd1);
        chk("wr_pwdata", PWDATA, 32'h5A5A_1234);
        tick();
        chk("wr_access_psel", 32'(PSEL), 32'd1);
        chk("wr_access_penable", 32'(PENABLE), 32'd1);
        chk("wr_access_rsp_valid", 32'(rsp_valid_o), 32'd0);
        tick();
        chk("wr_resp_valid", 32'(rsp_valid_o), 32'd1);
        chk("wr_resp_psel", 32'(PSEL), 32'd0);
        chk("wr_resp_rdata", rsp_rdata_o, 32'd0);
        tick();
        chk("wr_back_idle", 32'(req_ready_o), 32'd1);
        chk("wr_pwdata_hold", PWDATA, 32'h5A5A_1234);

        // Read with three wait states.
        tie_ready   = 0;
        wait_states = 3;
        slave_rdata = 32'hCAFE_F00D;
        do_req(12'h004, 1'b0, 32'h0);
        wait_rsp(n, en);
        chk("rd_wait_latency", 32'(n), 32'd5);
        chk("rd_wait_penable_cycles", 32'(en), 32'd4);
        chk("rd_wait_rdata", rsp_rdata_o, 32'hCAFE_F00D);
        tick();

        // Slave error with a stalled response channel.
        wait_states = 0;
        slave_rdata = 32'h1234_5678;
        slave_err   = 1'b1;
        rsp_ready_i = 1'b0;
        do_req(12'h020, 1'b0, 32'h0);
        wait_rsp(n, en);
        slave_err   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("err_hold_valid", 32'(rsp_valid_o), 32'd1);
            chk("err_hold_rdata", rsp_rdata_o, 32'h1234_5678);
            chk("err_hold_err", 32'(rsp_err_o), 32'd1);
            chk("err_hold_req_ready", 32'(req_ready_o), 32'd0);
            slave_rdata = 32'hDEAD_0000 + 32'(k);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        chk("err_back_idle", 32'(req_ready_o), 32'd1);

        // Eight back-to-back requests with valid held high.
        rd_mix      = 1;
        slave_rdata = 32'hB0B0_0000;
        rsp_times.delete();
        i = 0;
        n = 0;
        rises = 0;
        psel_prev = PSEL;
        req_valid_i = 1'b1;
        req_addr_i  = 12'h100;
        req_write_i = 1'b0;
        req_wdata_i = 32'hA000_0000;
        while (rsp_times.size() < 8 && n < 100) begin
            tick();
            n++;
            if (PSEL === 1'b1 && psel_prev !== 1'b1) rises++;
            psel_prev = PSEL;
            if (last_acc) begin
                i++;
                if (i < 8) begin
                    req_addr_i  = 12'(12'h100 + 4 * i);
                    req_write_i = i[0];
                    req_wdata_i = 32'hA000_0000 + 32'(i);
                end else begin
                    req_valid_i = 1'b0;
                end
            end
        end
        req_valid_i = 1'b0;
        chk("b2b_responses", 32'(rsp_times.size()), 32'd8);
        chk("b2b_psel_pulses", 32'(rises), 32'd8);
        for (int k = 1; k < rsp_times.size(); k++) begin
            chk("b2b_spacing", 32'(rsp_times[k] - rsp_times[k-1]), 32'd4);
        end
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
        rd_mix = 0;

        // Reset during ACCESS discards the transfer.
        wait_states = 10;
        do_req(12'h0F0, 1'b0, 32'h0);
        tick();
        chk("rst_mid_penable_before", 32'(PENABLE), 32'd1);
        rst_n = 1'b0;
        tick();
        sb.delete();
        chk("rst_mid_psel", 32'(PSEL), 32'd0);
        chk("rst_mid_penable", 32'(PENABLE), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready_o), 32'd1);
        rst_n = 1'b1;
        wait_states = 0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid_o !== 1'b0) n++;
        end
        chk("rst_mid_no_rsp", 32'(n), 32'd0);
        slave_rdata = 32'h0BAD_CAFE;
        do_req(12'h0F4, 1'b0, 32'h0);
        wait_rsp(n, en);
        chk("post_rst_latency", 32'(n), 32'd2);
        tick();
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

`ifdef APB_UP_MASTER_TIMEOUT_EN
        // Timeout with PREADY held low, then completion on the limit cycle.
        wait_states    = 1000;
        slave_rdata    = 32'h7777_7777;
        expect_timeout = 1;
        do_req(12'h040, 1'b0, 32'h0);
        expect_timeout = 0;
        wait_rsp(n, en);
        chk("to_latency", 32'(n), 32'd6);
        chk("to_penable_cycles", 32'(en), 32'd5);
        chk("to_err", 32'(rsp_err_o), 32'd1);
        chk("to_rdata", rsp_rdata_o, 32'd0);
        chk("to_psel_dropped", 32'(PSEL), 32'd0);
        tick();
        wait_states = 4;
        do_req(12'h044, 1'b0, 32'h0);
        wait_rsp(n, en);
        chk("to_edge_latency", 32'(n), 32'd6);
        chk("to_edge_err", 32'(rsp_err_o), 32'd0);
        chk("to_edge_rdata", rsp_rdata_o, 32'h7777_7777);
        tick();
`endif

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
